// File: rtl/sram_async_ctl_if.sv
// rtl/sram_async_ctl_if.sv - CPU-side memory port of the async SRAM controller
interface sram_async_ctl_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              rd;
  logic              wr;
  logic              wr_inhibit;
  logic              byte_op;
  logic              done;

  modport master (
    output addr, data_in, rd, wr, wr_inhibit, byte_op,
    input  data_out, done
  );

  modport slave (
    input  addr, data_in, rd, wr, wr_inhibit, byte_op,
    output data_out, done
  );
endinterface

// File: rtl/sram_async_ctl.sv
// rtl/sram_async_ctl.sv - synchronous bus to multi-bank asynchronous SRAM controller with wait states
// Optional sticky bus protocol checker (bus_err) enabled by RAM_BUSCHECK_EN.
module sram_async_ctl #(
  parameter int ADDR_W  = 18,
  parameter int NBANKS  = 2,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  localparam int BSEL_W = (NBANKS > 1) ? $clog2(NBANKS) : 0,
  localparam int RA_W   = ADDR_W - 1 - BSEL_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sram_async_ctl_if.slave        bus,
  output logic [RA_W-1:0]        ram_a,
  output logic                   ram_oe_n,
  output logic                   ram_we_n,
  inout  wire  [16*NBANKS-1:0]   ram_io,
  output logic [NBANKS-1:0]      ram_ce_n,
  output logic [NBANKS-1:0]      ram_ub_n,
  output logic [NBANKS-1:0]      ram_lb_n
`ifdef RAM_BUSCHECK_EN
  ,
  output logic                   bus_err
`endif
);
  localparam int BK_W  = (BSEL_W > 0) ? BSEL_W : 1;
  localparam int MAXW  = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WSET, S_WPUL, S_WHLD, S_DONE, S_REL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0]  ra_q, ra_d;
  logic [BK_W-1:0]  bank_q, bank_d, bank_sel;
  logic             ub_q, ub_d, lb_q, lb_d;
  logic             inh_q, inh_d, byte_q, byte_d, hi_q, hi_d;
  logic [15:0]      wdata_q, wdata_d, dout_q, dout_d;
  logic [15:0]      rword;
  logic             active, driving;

  generate
    if (BSEL_W > 0) begin : g_bsel
      assign bank_sel = bus.addr[ADDR_W-1 -: BSEL_W];
    end else begin : g_nobsel
      assign bank_sel = '0;
    end
  endgenerate

  assign rword = ram_io[16*int'(bank_q) +: 16];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    bank_d  = bank_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    inh_d   = inh_q;
    byte_d  = byte_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rd || bus.wr) begin
          ra_d    = bus.addr[ADDR_W-2-BSEL_W+1:1];
          bank_d  = bank_sel;
          ub_d    = ~bus.byte_op | bus.addr[0];
          lb_d    = ~bus.byte_op | ~bus.addr[0];
          byte_d  = bus.byte_op;
          hi_d    = bus.addr[0];
          inh_d   = bus.wr_inhibit;
          // byte writes put the byte on both lanes; the lane enable picks the target
          wdata_d = bus.byte_op ? {2{bus.data_in[7:0]}} : bus.data_in;
          cnt_d   = '0;
          state_d = bus.rd ? S_RD : S_WSET;
        end
      end
      S_RD: begin
        if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
          dout_d  = byte_q ? {8'h00, (hi_q ? rword[15:8] : rword[7:0])} : rword;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WSET: begin
        cnt_d   = '0;
        state_d = S_WPUL;
      end
      S_WPUL: begin
        if (cnt_q == CNT_W'(WR_WAIT - 1)) begin
          state_d = S_WHLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WHLD:  state_d = S_DONE;
      S_DONE:  state_d = (bus.rd || bus.wr) ? S_REL : S_IDLE;
      S_REL:   if (!bus.rd && !bus.wr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      bank_q  <= '0;
      ub_q    <= 1'b0;
      lb_q    <= 1'b0;
      inh_q   <= 1'b0;
      byte_q  <= 1'b0;
      hi_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      bank_q  <= bank_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      inh_q   <= inh_d;
      byte_q  <= byte_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  // strobes decode straight from state so an async reset drops them at once
  assign active  = (state_q == S_RD) || (state_q == S_WSET) ||
                   (state_q == S_WPUL) || (state_q == S_WHLD);
  assign driving = ((state_q == S_WSET) || (state_q == S_WPUL) ||
                    (state_q == S_WHLD)) && !inh_q;

  assign ram_a        = ra_q;
  assign ram_oe_n     = ~(state_q == S_RD);
  assign ram_we_n     = ~((state_q == S_WPUL) && !inh_q);
  assign bus.done     = (state_q == S_DONE);
  assign bus.data_out = dout_q;

  generate
    for (genvar k = 0; k < NBANKS; k++) begin : g_bank
      logic sel;
      assign sel                = active && (int'(bank_q) == k);
      assign ram_ce_n[k]        = ~sel;
      assign ram_ub_n[k]        = ~(sel && ub_q);
      assign ram_lb_n[k]        = ~(sel && lb_q);
      assign ram_io[16*k +: 16] = (sel && driving) ? wdata_q : 16'hzzzz;
    end
  endgenerate

`ifdef RAM_BUSCHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == S_IDLE) && bus.rd && bus.wr) err_d = 1'b1;
    if (active && !(bus.rd || bus.wr))           err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus_err = err_q;
`endif
endmodule
